// File: rtl/byte_lane_serializer_if.sv
// ---------------------------------------------------------------------------
// byte_lane_serializer_if
// Purpose : bundles the word-side and byte-side handshake signals of
//           byte_lane_serializer.
// Signals : in_valid/in_ready/in_data/in_mask  - packed word input
//           out_valid/out_ready/out_byte/out_last - byte stream output
//           empty_drop - pulse when an all-disabled word is discarded
//           bytes_sent - free-running count of output handshakes
// Modports: master - the environment (word producer + byte consumer)
//           slave  - the serializer itself
// ---------------------------------------------------------------------------
interface byte_lane_serializer_if #(
  parameter int LANES = 4,
  parameter int CNT_W = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES-1:0][7:0] in_data;
  logic [LANES-1:0]      in_mask;
  logic                  out_valid;
  logic                  out_ready;
  logic [7:0]            out_byte;
  logic                  out_last;
  logic                  empty_drop;
  logic [CNT_W-1:0]      bytes_sent;

  modport master (
    output in_valid, in_data, in_mask, out_ready,
    input  in_ready, out_valid, out_byte, out_last, empty_drop, bytes_sent
  );

  modport slave (
    input  in_valid, in_data, in_mask, out_ready,
    output in_ready, out_valid, out_byte, out_last, empty_drop, bytes_sent
  );
endinterface

// File: rtl/byte_lane_serializer.sv
// ---------------------------------------------------------------------------
// byte_lane_serializer
// Purpose : accepts a packed LANES x 8-bit word with a per-lane byte enable
//           and emits the enabled lanes one byte per cycle. Back-to-back
//           words stream with no bubble; a word with no enabled lanes is
//           discarded and flagged on empty_drop.
// Ports   : clk   - clock
//           rst_n - asynchronous active-low reset
//           bus   - byte_lane_serializer_if.slave (word in, byte out,
//                   empty_drop, bytes_sent)
// Options : define BYTE_LANE_SERIALIZER_MSB_FIRST_EN to emit lanes from the
//           highest enabled index downward; default is lowest index first.
// ---------------------------------------------------------------------------
module byte_lane_serializer #(
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  byte_lane_serializer_if.slave  bus
);

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                r_state;
  logic [LANES-1:0][7:0] r_hold_data;
  logic [LANES-1:0]      r_hold_mask;
  logic [IDX_W-1:0]      r_lane_idx;
  logic                  r_out_valid;
  logic [7:0]            r_out_byte;
  logic                  r_out_last;
  logic                  r_empty_drop;
  logic [CNT_W-1:0]      r_bytes_sent;

  // First lane to emit from a mask in the configured direction.
  function automatic logic [IDX_W-1:0] first_lane(input logic [LANES-1:0] m);
    logic [IDX_W-1:0] k;
    k = '0;
`ifdef BYTE_LANE_SERIALIZER_MSB_FIRST_EN
    for (int i = 0; i < LANES; i++)
      if (m[i]) k = IDX_W'(i);
`else
    for (int i = LANES - 1; i >= 0; i--)
      if (m[i]) k = IDX_W'(i);
`endif
    return k;
  endfunction

  // True when the given lane is the only one set in the mask.
  function automatic logic only_lane(input logic [LANES-1:0] m,
                                     input logic [IDX_W-1:0] lane);
    logic [LANES-1:0] t;
    t       = m;
    t[lane] = 1'b0;
    return (t == '0);
  endfunction

  // Enabled lanes still ahead of the current lane in emission order.
  logic [LANES-1:0] w_ahead_mask;
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_ahead
`ifdef BYTE_LANE_SERIALIZER_MSB_FIRST_EN
      assign w_ahead_mask[gi] = r_hold_mask[gi] && (IDX_W'(gi) < r_lane_idx);
`else
      assign w_ahead_mask[gi] = r_hold_mask[gi] && (IDX_W'(gi) > r_lane_idx);
`endif
    end
  endgenerate

  logic             w_out_hs;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_in_nz;
  logic [IDX_W-1:0] w_load_lane;
  logic             w_load_last;
  logic [IDX_W-1:0] w_adv_lane;
  logic             w_adv_last;

  assign w_out_hs    = r_out_valid && bus.out_ready;
  // A new word may enter while the last byte of the current one leaves.
  assign w_in_ready  = (r_state == IDLE) || (w_out_hs && r_out_last);
  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_in_nz     = (bus.in_mask != '0);
  assign w_load_lane = first_lane(bus.in_mask);
  assign w_load_last = only_lane(bus.in_mask, w_load_lane);
  assign w_adv_lane  = first_lane(w_ahead_mask);
  assign w_adv_last  = only_lane(w_ahead_mask, w_adv_lane);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_hold_data  <= '0;
      r_hold_mask  <= '0;
      r_lane_idx   <= '0;
      r_out_valid  <= 1'b0;
      r_out_byte   <= 8'h00;
      r_out_last   <= 1'b0;
      r_empty_drop <= 1'b0;
      r_bytes_sent <= '0;
    end else begin
      r_empty_drop <= 1'b0;
      if (w_out_hs)
        r_bytes_sent <= r_bytes_sent + CNT_W'(1);

      // An accepted word implies the current word is finished (or none was
      // held), so loading always replaces the held word outright.
      if (w_accept && w_in_nz) begin
        r_hold_data <= bus.in_data;
        r_hold_mask <= bus.in_mask;
        r_lane_idx  <= w_load_lane;
        r_out_byte  <= bus.in_data[w_load_lane];
        r_out_last  <= w_load_last;
        r_out_valid <= 1'b1;
        r_state     <= SHIFT;
      end else if (w_accept) begin
        r_empty_drop <= 1'b1;
        r_out_valid  <= 1'b0;
        r_state      <= IDLE;
      end else if (w_out_hs) begin
        if (!r_out_last) begin
          r_lane_idx <= w_adv_lane;
          r_out_byte <= r_hold_data[w_adv_lane];
          r_out_last <= w_adv_last;
        end else begin
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_byte   = r_out_byte;
  assign bus.out_last   = r_out_last;
  assign bus.empty_drop = r_empty_drop;
  assign bus.bytes_sent = r_bytes_sent;

endmodule

// File: tb/tb_byte_lane_serializer.sv
// ---------------------------------------------------------------------------
// tb_byte_lane_serializer
// Drives words into byte_lane_serializer and compares every cycle against a
// queue-based model: each accepted word becomes a list of expected bytes,
// popped on each output handshake. Directed sequences with literal
// expectations pin the model; a random phase and a counter wrap follow.
// ---------------------------------------------------------------------------
module tb_byte_lane_serializer;
  localparam int L  = 4;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  byte_lane_serializer_if #(.LANES(L), .CNT_W(CW)) bus ();

  byte_lane_serializer #(.LANES(L), .CNT_W(CW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // Model state: expected bytes {last, byte}, count, drop pulse.
  logic [8:0]    q[$];
  logic [CW-1:0] m_cnt  = '0;
  logic          m_drop = 1'b0;
  logic [7:0]    log_q[$];

  logic              cur_v = 1'b0;
  logic [L-1:0][7:0] cur_d = '0;
  logic [L-1:0]      cur_m = '0;
  logic              cur_r = 1'b1;
  logic              last_acc = 1'b0;
  logic              last_in_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic note_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=timeout expected=done t=%0t", name, $time);
  endtask

  task automatic push_word(input logic [L-1:0][7:0] d, input logic [L-1:0] m);
    logic [7:0] s[$];
`ifdef BYTE_LANE_SERIALIZER_MSB_FIRST_EN
    for (int k = L - 1; k >= 0; k--) if (m[k]) s.push_back(d[k]);
`else
    for (int k = 0; k < L; k++) if (m[k]) s.push_back(d[k]);
`endif
    for (int j = 0; j < s.size(); j++)
      q.push_back({(j == s.size() - 1), s[j]});
  endtask

  task automatic check_outputs();
    chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("out_byte", 32'(bus.out_byte), 32'(q[0][7:0]));
      chk("out_last", 32'(bus.out_last), 32'(q[0][8]));
    end
    chk("empty_drop", 32'(bus.empty_drop), 32'(m_drop));
    chk("bytes_sent", 32'(bus.bytes_sent), 32'(m_cnt));
  endtask

  // One clock cycle: entered and left at a falling edge.
  task automatic tick();
    logic m_rdy, acc, ohs;
    bus.in_valid  = cur_v;
    bus.in_data   = cur_d;
    bus.in_mask   = cur_m;
    bus.out_ready = cur_r;
    #1;
    m_rdy = (q.size() == 0) || (q[0][8] && cur_r);
    chk("in_ready", 32'(bus.in_ready), 32'(m_rdy));
    last_in_ready = bus.in_ready;
    acc = cur_v && m_rdy;
    ohs = (q.size() != 0) && cur_r;
    if (bus.out_valid && cur_r) log_q.push_back(bus.out_byte);
    @(posedge clk);
    if (ohs) begin
      void'(q.pop_front());
      m_cnt = m_cnt + 1'b1;
    end
    m_drop = acc && (cur_m == '0);
    if (acc && cur_m != '0) push_word(cur_d, cur_m);
    last_acc = acc;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic send_word(input logic [31:0] d, input logic [3:0] m);
    int n;
    cur_v = 1'b1;
    cur_d = d;
    cur_m = m;
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 50);
    if (!last_acc) note_fail("send_word");
    cur_v = 1'b0;
  endtask

  task automatic drain();
    int n;
    cur_v = 1'b0;
    cur_r = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 30) begin
      tick();
      n++;
    end
    if (q.size() != 0) note_fail("drain");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_bytes_sent", 32'(bus.bytes_sent), 32'd0);
    q.delete();
    m_cnt  = '0;
    m_drop = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_log(input string name, input int n, input logic [31:0] exp);
    chk({name, "_count"}, 32'(log_q.size()), 32'(n));
    for (int i = 0; i < n && i < log_q.size(); i++)
      chk(name, 32'(log_q[i]), 32'(exp[8*i +: 8]));
    log_q.delete();
  endtask

  logic [31:0] e_full, e_0101, e_b2b;
  logic [7:0]  e_stall;

  initial begin
`ifdef BYTE_LANE_SERIALIZER_MSB_FIRST_EN
    e_full  = 32'hAABBCCDD;
    e_0101  = 32'h0000AACC;
    e_b2b   = 32'h001122DD;
    e_stall = 8'hCC;
`else
    e_full  = 32'hDDCCBBAA;
    e_0101  = 32'h0000CCAA;
    e_b2b   = 32'h002211DD;
    e_stall = 8'hBB;
`endif
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_mask   = '0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    do_reset();
    chk("rst_out_byte", 32'(bus.out_byte), 32'h00);
    chk("rst_out_last", 32'(bus.out_last), 32'd0);
    chk("rst_empty_drop", 32'(bus.empty_drop), 32'd0);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Full word.
    cur_r = 1'b1;
    send_word(32'hDDCCBBAA, 4'b1111);
    drain();
    check_log("full_word", 4, e_full);
    chk("full_count", 32'(bus.bytes_sent), 32'd4);

    // Sparse mask, in_ready low on the non-last byte.
    send_word(32'hDDCCBBAA, 4'b0101);
    tick();
    chk("sparse_rdy_first", 32'(last_in_ready), 32'd0);
    tick();
    chk("sparse_rdy_last", 32'(last_in_ready), 32'd1);
    drain();
    check_log("sparse", 2, e_0101);

    // Back-to-back words, no gap.
    send_word(32'hDDCCBBAA, 4'b1000);
    send_word(32'h44332211, 4'b0011);
    drain();
    check_log("b2b", 3, e_b2b);
    chk("b2b_count", 32'(bus.bytes_sent), 32'd9);

    // Zero mask word.
    send_word(32'h12345678, 4'b0000);
    chk("drop_pulse", 32'(bus.empty_drop), 32'd1);
    chk("drop_no_valid", 32'(bus.out_valid), 32'd0);
    chk("drop_count", 32'(bus.bytes_sent), 32'd9);
    tick();
    chk("drop_pulse_end", 32'(bus.empty_drop), 32'd0);

    // Stall on the second byte, then reset mid-word.
    cur_r = 1'b0;
    send_word(32'hDDCCBBAA, 4'b1111);
    cur_r = 1'b1;
    tick();
    cur_r = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_byte", 32'(bus.out_byte), 32'(e_stall));
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
    end
    do_reset();
    log_q.delete();
    cur_r = 1'b1;
    send_word(32'hDDCCBBAA, 4'b1111);
    drain();
    check_log("restart", 4, e_full);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cur_v = 1'($urandom_range(0, 1));
      cur_d = $urandom;
      cur_m = 4'($urandom_range(0, 15));
      cur_r = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();
    log_q.delete();

    // Counter wrap.
    do_reset();
    for (int i = 0; i < 63; i++) send_word($urandom, 4'b1111);
    send_word($urandom, 4'b0111);
    drain();
    chk("wrap_max", 32'(bus.bytes_sent), 32'hFF);
    send_word($urandom, 4'b0001);
    drain();
    chk("wrap_zero", 32'(bus.bytes_sent), 32'd0);
    log_q.delete();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
